// File: rtl/m_axi_burst_writer.sv
// AXI4 write-burst master: drains a FWFT FIFO into INCR bursts bounded by
// MAX_BURST and 4 KB pages, tracks outstanding B responses, pulses done.
module m_axi_burst_writer #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned LEN_WIDTH       = 32,
  parameter int unsigned MAX_BURST       = 16,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk_en,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  output logic                    done,
  output logic                    err,
  input  logic                    in_empty_n,
  output logic                    in_read,
  input  logic [DATA_WIDTH-1:0]   in_dout,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic [7:0]              m_awlen,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wlast,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  input  logic [1:0]              m_bresp
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned BYTE_SHIFT = $clog2(STRB_WIDTH);
  localparam logic [8:0]  MAX_BEATS  = 9'(MAX_BURST);
  localparam logic [3:0]  MAX_OUT    = 4'(MAX_OUTSTANDING);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ADDR  = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]            state, state_d;
  logic [ADDR_WIDTH-1:0] addr, addr_d;
  logic [LEN_WIDTH-1:0]  remain, remain_d;
  logic [8:0]            beat, beat_d;
  logic [8:0]            blen, blen_d;
  logic [7:0]            awlen_d;
  logic [3:0]            outst, outst_d;
  logic                  cmd_ready_d, done_d, err_d, awvalid_d, wlast_d;
  logic                  aw_hs, w_hs;

  // Beats for the next burst: min(MAX_BURST, words left, words to the 4 KB page end)
  function automatic logic [8:0] burst_beats(input logic [ADDR_WIDTH-1:0] a,
                                             input logic [LEN_WIDTH-1:0]  r);
    logic [12:0] room;
    logic [8:0]  b;
    room = (13'd4096 - {1'b0, a[11:0]}) >> BYTE_SHIFT;
    b    = MAX_BEATS;
    if (r < LEN_WIDTH'(MAX_BURST)) b = 9'(r);
    if ({4'd0, b} > room) b = 9'(room);
    return b;
  endfunction

  // W beats are withheld while the engine is frozen or in reset so no FIFO word is lost
  assign m_wvalid = (state == DATA) & in_empty_n & clk_en & ~reset;
  assign w_hs     = m_wvalid & m_wready;
  assign in_read  = w_hs;
  assign m_wdata  = (state == DATA) ? in_dout : '0;
  assign m_wstrb  = '1;
  assign m_bready = 1'b1;
  assign m_awaddr = addr;
  assign aw_hs    = m_awvalid & m_awready;

  always_comb begin
    state_d  = state;
    addr_d   = addr;
    remain_d = remain;
    beat_d   = beat;
    blen_d   = blen;
    awlen_d  = m_awlen;
    outst_d  = outst;
    err_d    = err;
    done_d   = 1'b0;

    if (aw_hs && !m_bvalid) begin
      outst_d = outst + 4'd1;
    end else if (!aw_hs && m_bvalid && outst != 4'd0) begin
      outst_d = outst - 4'd1;
    end
    if (m_bvalid && m_bresp != 2'b00) err_d = 1'b1;

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d   = cmd_addr;
          remain_d = cmd_len;
          beat_d   = 9'd0;
          err_d    = 1'b0;
          state_d  = (cmd_len == '0) ? DRAIN : ADDR;
        end
      end
      ADDR: begin
        if (aw_hs) begin
          addr_d   = addr + (ADDR_WIDTH'(blen) << BYTE_SHIFT);
          remain_d = remain - LEN_WIDTH'(blen);
          beat_d   = 9'd0;
          state_d  = DATA;
        end
      end
      DATA: begin
        if (w_hs) begin
          if (beat == blen - 9'd1) begin
            beat_d  = 9'd0;
            state_d = (remain != '0) ? ADDR : DRAIN;
          end else begin
            beat_d = beat + 9'd1;
          end
        end
      end
      DRAIN: begin
        // Includes a B arriving this cycle, so done follows the final B by one cycle
        if (outst_d == 4'd0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == ADDR) begin
      blen_d  = burst_beats(addr_d, remain_d);
      awlen_d = 8'(blen_d - 9'd1);
    end

    cmd_ready_d = (state_d == IDLE);
    awvalid_d   = (state_d == ADDR) && (outst_d < MAX_OUT);
    wlast_d     = (state_d == DATA) && (beat_d == blen_d - 9'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= '0;
      remain    <= '0;
      beat      <= '0;
      blen      <= '0;
      outst     <= '0;
      m_awlen   <= '0;
      err       <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b1;
      m_awvalid <= 1'b0;
      m_wlast   <= 1'b0;
    end else if (clk_en) begin
      state     <= state_d;
      addr      <= addr_d;
      remain    <= remain_d;
      beat      <= beat_d;
      blen      <= blen_d;
      outst     <= outst_d;
      m_awlen   <= awlen_d;
      err       <= err_d;
      done      <= done_d;
      cmd_ready <= cmd_ready_d;
      m_awvalid <= awvalid_d;
      m_wlast   <= wlast_d;
    end
  end

endmodule
